// File: rtl/systolic_feeder.sv
// Feeder for an NxN systolic PE array: buffers A row-wise and B column-wise,
// then streams both diagonally skewed into the array edges and flushes it.
module systolic_feeder_lane #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int LANE  = 0,
  parameter int TW    = 4
) (
  input  logic [N-1:0][WIDTH-1:0] vec,
  input  logic [TW-1:0]           t,
  input  logic                    en,
  output logic [WIDTH-1:0]        val
);
  localparam int IW = $clog2(N);
  localparam logic [TW-1:0] LO = TW'(LANE);
  localparam logic [TW-1:0] NW = TW'(N);

  logic [TW-1:0] d;

  // t < LANE wraps d to >= 2N+1 because 2^TW >= 3N, so one compare bounds both sides
  always_comb begin
    d   = t - LO;
    val = '0;
    if (en && d < NW) val = vec[d[IW-1:0]];
  end
endmodule

module systolic_feeder #(
  parameter int WIDTH = 8,
  parameter int N     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   wr_sel,
  input  logic [$clog2(N)-1:0]   wr_row,
  input  logic [$clog2(N)-1:0]   wr_col,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   pe_clr,
  output logic [N*WIDTH-1:0]     a_out,
  output logic [N*WIDTH-1:0]     b_out
);
  localparam int TW = $clog2(3*N);
  localparam logic [TW-1:0] FEED_LAST  = TW'(2*N-2);
  localparam logic [TW-1:0] FLUSH_LAST = TW'(3*N-3);

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, FLUSH, DONE} state_t;

  state_t state, state_nxt;
  logic [TW-1:0] t, t_nxt;
  logic feed_nxt, busy_nxt, done_nxt, clr_nxt;
  logic [N-1:0][N-1:0][WIDTH-1:0] a_buf, b_buf, b_col;
  logic [N-1:0][WIDTH-1:0] a_nxt, b_nxt;

  genvar g, r;
  generate
    for (g = 0; g < N; g++) begin : g_lane
      for (r = 0; r < N; r++) begin : g_col
        assign b_col[g][r] = b_buf[r][g];
      end
      systolic_feeder_lane #(.WIDTH(WIDTH), .N(N), .LANE(g), .TW(TW)) u_a (
        .vec(a_buf[g]), .t(t_nxt), .en(feed_nxt), .val(a_nxt[g]));
      systolic_feeder_lane #(.WIDTH(WIDTH), .N(N), .LANE(g), .TW(TW)) u_b (
        .vec(b_col[g]), .t(t_nxt), .en(feed_nxt), .val(b_nxt[g]));
    end
  endgenerate

  // Lanes are computed from the next-cycle t so every output leaves a flop
  always_comb begin
    state_nxt = state;
    t_nxt     = t;
    feed_nxt  = 1'b0;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    clr_nxt   = 1'b0;
    case (state)
      IDLE: begin
        busy_nxt = 1'b0;
        if (start) begin
          state_nxt = CLEAR;
          busy_nxt  = 1'b1;
          clr_nxt   = 1'b1;
        end
      end
      CLEAR: begin
        state_nxt = FEED;
        t_nxt     = '0;
        feed_nxt  = 1'b1;
      end
      FEED: begin
        t_nxt = t + TW'(1);
        if (t == FEED_LAST) state_nxt = FLUSH;
        else                feed_nxt  = 1'b1;
      end
      FLUSH: begin
        if (t == FLUSH_LAST) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
        end else begin
          t_nxt = t + TW'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      t      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      pe_clr <= 1'b0;
      a_out  <= '0;
      b_out  <= '0;
      a_buf  <= '0;
      b_buf  <= '0;
    end else begin
      state  <= state_nxt;
      t      <= t_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
      pe_clr <= clr_nxt;
      a_out  <= a_nxt;
      b_out  <= b_nxt;
      if (wr_en && !busy) begin
        if (!wr_sel) a_buf[wr_row][wr_col] <= wr_data;
        else         b_buf[wr_row][wr_col] <= wr_data;
      end
    end
  end
endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: N=2 and N=4 instances, each driving a behavioural PE grid.
module tb_systolic_feeder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic wr_en2, wr_sel2, start2, busy2, done2, clr2;
  logic [0:0] wr_row2, wr_col2;
  logic [7:0] wr_data2;
  logic [15:0] a_out2, b_out2;

  logic wr_en4, wr_sel4, start4, busy4, done4, clr4;
  logic [1:0] wr_row4, wr_col4;
  logic [7:0] wr_data4;
  logic [31:0] a_out4, b_out4;

  int checks = 0;
  int errors = 0;

  logic [15:0] c2 [2][2];
  logic [7:0]  ar2 [2][2], br2 [2][2];
  logic [15:0] c4 [4][4];
  logic [7:0]  ar4 [4][4], br4 [4][4];
  logic [15:0] exp4 [4][4];

  logic [15:0] ea2 [6] = '{16'h0000, 16'h0001, 16'h0302, 16'h0400, 16'h0000, 16'h0000};
  logic [15:0] eb2 [6] = '{16'h0000, 16'h0005, 16'h0607, 16'h0800, 16'h0000, 16'h0000};
  logic [15:0] ec2 [4] = '{16'd19, 16'd22, 16'd43, 16'd50};

  systolic_feeder #(.WIDTH(8), .N(2)) u_dut2 (
    .clk(clk), .rst(rst), .wr_en(wr_en2), .wr_sel(wr_sel2), .wr_row(wr_row2),
    .wr_col(wr_col2), .wr_data(wr_data2), .start(start2), .busy(busy2),
    .done(done2), .pe_clr(clr2), .a_out(a_out2), .b_out(b_out2));

  systolic_feeder #(.WIDTH(8), .N(4)) u_dut4 (
    .clk(clk), .rst(rst), .wr_en(wr_en4), .wr_sel(wr_sel4), .wr_row(wr_row4),
    .wr_col(wr_col4), .wr_data(wr_data4), .start(start4), .busy(busy4),
    .done(done4), .pe_clr(clr4), .a_out(a_out4), .b_out(b_out4));

  // Output-stationary PE: c += a*b, a passes right, b passes down, pe_clr clears
  always @(posedge clk) begin : pe2_model
    logic [7:0] ai, bi;
    logic [15:0] p;
    for (int i = 0; i < 2; i++) for (int j = 0; j < 2; j++) begin
      ai = (j == 0) ? a_out2[i*8 +: 8] : ar2[i][(j+1)%2];
      bi = (i == 0) ? b_out2[j*8 +: 8] : br2[(i+1)%2][j];
      p  = {8'd0, ai} * {8'd0, bi};
      c2[i][j]  <= clr2 ? 16'd0 : c2[i][j] + p;
      ar2[i][j] <= clr2 ? 8'd0 : ai;
      br2[i][j] <= clr2 ? 8'd0 : bi;
    end
  end

  always @(posedge clk) begin : pe4_model
    logic [7:0] ai, bi;
    logic [15:0] p;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) begin
      ai = (j == 0) ? a_out4[i*8 +: 8] : ar4[i][(j+3)%4];
      bi = (i == 0) ? b_out4[j*8 +: 8] : br4[(i+3)%4][j];
      p  = {8'd0, ai} * {8'd0, bi};
      c4[i][j]  <= clr4 ? 16'd0 : c4[i][j] + p;
      ar4[i][j] <= clr4 ? 8'd0 : ai;
      br4[i][j] <= clr4 ? 8'd0 : bi;
    end
  end

  task automatic wr2(input logic sel, input int r, input int c, input int d);
    wr_en2 = 1'b1; wr_sel2 = sel; wr_row2 = 1'(r); wr_col2 = 1'(c); wr_data2 = 8'(d);
    @(negedge clk);
    wr_en2 = 1'b0;
  endtask

  task automatic wr4(input logic sel, input int r, input int c, input int d);
    wr_en4 = 1'b1; wr_sel4 = sel; wr_row4 = 2'(r); wr_col4 = 2'(c); wr_data4 = 8'(d);
    @(negedge clk);
    wr_en4 = 1'b0;
  endtask

  task automatic test_reset();
    wr_en2 = 0; wr_sel2 = 0; start2 = 0; wr_row2 = 0; wr_col2 = 0; wr_data2 = 0;
    wr_en4 = 0; wr_sel4 = 0; start4 = 0; wr_row4 = 0; wr_col4 = 0; wr_data4 = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({busy2, done2, clr2} !== 3'b000) begin errors++; $display("FAIL reset_ctl2: got %b want 000", {busy2, done2, clr2}); end
    checks++; if ({a_out2, b_out2} !== 32'd0) begin errors++; $display("FAIL reset_lanes2: got %h want 0", {a_out2, b_out2}); end
    checks++; if ({busy4, done4, clr4} !== 3'b000) begin errors++; $display("FAIL reset_ctl4: got %b want 000", {busy4, done4, clr4}); end
    checks++; if ({a_out4, b_out4} !== 64'd0) begin errors++; $display("FAIL reset_lanes4: got %h want 0", {a_out4, b_out4}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_n2_basic();
    int av[4] = '{1, 2, 3, 4};
    int bv[4] = '{5, 6, 7, 8};
    for (int i = 0; i < 4; i++) begin
      wr2(1'b0, i / 2, i % 2, av[i]);
      wr2(1'b1, i / 2, i % 2, bv[i]);
    end
    start2 = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      start2 = 1'b0;
      checks++; if (clr2 !== (k == 0)) begin errors++; $display("FAIL n2_clr k=%0d: got %b", k, clr2); end
      checks++; if (done2 !== (k == 5)) begin errors++; $display("FAIL n2_done k=%0d: got %b", k, done2); end
      checks++; if (busy2 !== (k <= 5)) begin errors++; $display("FAIL n2_busy k=%0d: got %b", k, busy2); end
      if (k <= 5) begin
        checks++; if (a_out2 !== ea2[k]) begin errors++; $display("FAIL n2_a k=%0d: got %h want %h", k, a_out2, ea2[k]); end
        checks++; if (b_out2 !== eb2[k]) begin errors++; $display("FAIL n2_b k=%0d: got %h want %h", k, b_out2, eb2[k]); end
      end
      if (k == 5) for (int i = 0; i < 4; i++) begin
        checks++; if (c2[i/2][i%2] !== ec2[i]) begin errors++; $display("FAIL n2_c[%0d]: got %0d want %0d", i, c2[i/2][i%2], ec2[i]); end
      end
    end
  endtask

  task automatic test_start_held();
    start2 = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      if (k == 20) start2 = 1'b0;
      checks++; if (clr2 !== (k % 7 == 0)) begin errors++; $display("FAIL held_clr k=%0d: got %b", k, clr2); end
      checks++; if (done2 !== (k % 7 == 5)) begin errors++; $display("FAIL held_done k=%0d: got %b", k, done2); end
      checks++; if (busy2 !== (k % 7 != 6)) begin errors++; $display("FAIL held_busy k=%0d: got %b", k, busy2); end
      if (k % 7 == 5) for (int i = 0; i < 4; i++) begin
        checks++; if (c2[i/2][i%2] !== ec2[i]) begin errors++; $display("FAIL held_c k=%0d [%0d]: got %0d want %0d", k, i, c2[i/2][i%2], ec2[i]); end
      end
    end
  endtask

  // One N=4 run from IDLE; with disturb, writes and start pulse during FEED
  task automatic run4(input logic disturb);
    start4 = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      start4   = disturb && k >= 1 && k <= 6;
      wr_en4   = disturb && k >= 1 && k <= 6;
      wr_sel4  = k[0];
      wr_row4  = 2'(k % 4);
      wr_col4  = 2'((k + 1) % 4);
      wr_data4 = 8'd0;
      checks++; if (clr4 !== (k == 0)) begin errors++; $display("FAIL n4_clr k=%0d: got %b", k, clr4); end
      checks++; if (done4 !== (k == 11)) begin errors++; $display("FAIL n4_done k=%0d: got %b", k, done4); end
      checks++; if (busy4 !== (k <= 11)) begin errors++; $display("FAIL n4_busy k=%0d: got %b", k, busy4); end
      if (k == 11) for (int i = 0; i < 16; i++) begin
        checks++; if (c4[i/4][i%4] !== exp4[i/4][i%4]) begin errors++; $display("FAIL n4_c[%0d][%0d]: got %0d want %0d", i/4, i%4, c4[i/4][i%4], exp4[i/4][i%4]); end
      end
    end
    wr_en4 = 1'b0;
  endtask

  task automatic test_identity();
    for (int i = 0; i < 16; i++) begin
      wr4(1'b0, i / 4, i % 4, (i / 4 == i % 4) ? 1 : 0);
      wr4(1'b1, i / 4, i % 4, i + 1);
      exp4[i/4][i%4] = 16'(i + 1);
    end
    run4(1'b0);
  endtask

  task automatic test_reset_mid();
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (a_out4 !== 32'd0) begin errors++; $display("FAIL mid_a_t3: got %h want 0", a_out4); end
    checks++; if (b_out4 !== 32'h04070A0D) begin errors++; $display("FAIL mid_b_t3: got %h want 04070a0d", b_out4); end
    #1 rst = 1'b1;
    #1;
    checks++; if ({busy4, done4, clr4} !== 3'b000) begin errors++; $display("FAIL mid_rst_ctl: got %b want 000", {busy4, done4, clr4}); end
    checks++; if ({a_out4, b_out4} !== 64'd0) begin errors++; $display("FAIL mid_rst_lanes: got %h want 0", {a_out4, b_out4}); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    // buffers were cleared by reset, so a fresh run must wipe the stale partial sums
    for (int i = 0; i < 16; i++) exp4[i/4][i%4] = 16'd0;
    run4(1'b0);
  endtask

  task automatic test_wrap_and_busy_writes();
    for (int i = 0; i < 16; i++) begin
      wr4(1'b0, i / 4, i % 4, 255);
      wr4(1'b1, i / 4, i % 4, 255);
      exp4[i/4][i%4] = 16'd63492;
    end
    run4(1'b0);
    run4(1'b1);
    run4(1'b0);
  endtask

  initial begin
    test_reset();
    test_n2_basic();
    test_start_held();
    test_identity();
    test_reset_mid();
    test_wrap_and_busy_writes();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
